// File: rtl/clk_div_monitor_if.sv
// Bundle between a divided-clock checker and its observer.
// The checker takes the slave side; the stimulus/readout takes the master side.
interface clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             mon_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period_cnt;
  logic             meas_valid;
  logic             duty_err;
  logic             period_err;
  logic             stuck_err;
  logic             locked;
  logic [7:0]       err_count;

  modport master (
    output enable, mon_in,
    input  high_cnt, low_cnt, period_cnt, meas_valid,
    input  duty_err, period_err, stuck_err, locked, err_count
  );

  modport slave (
    input  enable, mon_in,
    output high_cnt, low_cnt, period_cnt, meas_valid,
    output duty_err, period_err, stuck_err, locked, err_count
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Samples a divided clock with clk, measures high/low/period lengths,
// flags duty/period/stuck errors and declares lock after a run of good periods.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | measurement disabled
// WAIT_RISE   | discarding a partial period until the next rising edge
// MEAS_HIGH   | counting the high phase
// MEAS_LOW    | counting the low phase; next rise publishes the measurement
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HIGH = 3,
  parameter int EXP_LOW  = 3,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  clk_div_monitor_if.slave  mon
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_RISE = 2'd1;
  localparam logic [1:0] S_MEAS_HIGH = 2'd2;
  localparam logic [1:0] S_MEAS_LOW  = 2'd3;

  localparam int               EXP_PER  = EXP_HIGH + EXP_LOW;
  localparam logic [CNT_W+1:0] TOL_W    = TOL[CNT_W+1:0];
  localparam logic [CNT_W+1:0] EXP_H_W  = EXP_HIGH[CNT_W+1:0];
  localparam logic [CNT_W+1:0] EXP_L_W  = EXP_LOW[CNT_W+1:0];
  localparam logic [CNT_W+1:0] EXP_P_W  = EXP_PER[CNT_W+1:0];
  localparam logic [3:0]       LOCK_W   = LOCK_CNT[3:0];
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sync1_q, sync2_q, prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [CNT_W-1:0] high_q, high_d, low_q, low_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             valid_q, valid_d, duty_q, duty_d, perr_q, perr_d;
  logic             stuck_q, stuck_d, locked_q, locked_d;
  logic [3:0]       good_q, good_d;
  logic [7:0]       errc_q, errc_d;

  logic             rise, fall, duty_bad, perr_bad;
  logic [CNT_W:0]   sum;
  logic [3:0]       good_step;
  logic [7:0]       errc_inc;

  function automatic logic out_of_tol(input logic [CNT_W+1:0] a,
                                      input logic [CNT_W+1:0] b);
    logic [CNT_W+1:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return diff > TOL_W;
  endfunction

  assign rise      = sync2_q & ~prev_q;
  assign fall      = ~sync2_q & prev_q;
  assign sum       = {1'b0, hcnt_q} + {1'b0, lcnt_q};
  assign duty_bad  = out_of_tol({2'b00, hcnt_q}, EXP_H_W) |
                     out_of_tol({2'b00, lcnt_q}, EXP_L_W);
  assign perr_bad  = out_of_tol({1'b0, sum}, EXP_P_W);
  assign good_step = (good_q == LOCK_W) ? LOCK_W : good_q + 4'd1;
  assign errc_inc  = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    high_d   = high_q;
    low_d    = low_q;
    period_d = period_q;
    valid_d  = 1'b0;
    duty_d   = duty_q;
    perr_d   = perr_q;
    stuck_d  = stuck_q;
    locked_d = locked_q;
    good_d   = good_q;
    errc_d   = errc_q;

    if (!mon.enable) begin
      state_d  = S_IDLE;
      locked_d = 1'b0;
      good_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_RISE;
        S_WAIT_RISE: begin
          if (rise) begin
            state_d = S_MEAS_HIGH;
            hcnt_d  = CNT_ONE;
          end
        end
        S_MEAS_HIGH: begin
          if (fall) begin
            state_d = S_MEAS_LOW;
            lcnt_d  = CNT_ONE;
          end else if (hcnt_q == CNT_MAX) begin
            state_d  = S_WAIT_RISE;
            stuck_d  = 1'b1;
            locked_d = 1'b0;
            good_d   = 4'd0;
            errc_d   = errc_inc;
          end else if (sync2_q) begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
        end
        S_MEAS_LOW: begin
          if (rise) begin
            // Publish and immediately start the next period from this edge.
            high_d   = hcnt_q;
            low_d    = lcnt_q;
            period_d = sum;
            valid_d  = 1'b1;
            duty_d   = duty_bad;
            perr_d   = perr_bad;
            hcnt_d   = CNT_ONE;
            state_d  = S_MEAS_HIGH;
            if (duty_bad || perr_bad) begin
              good_d   = 4'd0;
              locked_d = 1'b0;
              errc_d   = errc_inc;
            end else begin
              good_d   = good_step;
              locked_d = (good_step == LOCK_W);
            end
          end else if (lcnt_q == CNT_MAX) begin
            state_d  = S_WAIT_RISE;
            stuck_d  = 1'b1;
            locked_d = 1'b0;
            good_d   = 4'd0;
            errc_d   = errc_inc;
          end else if (!sync2_q) begin
            lcnt_d = lcnt_q + CNT_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      duty_q   <= 1'b0;
      perr_q   <= 1'b0;
      stuck_q  <= 1'b0;
      locked_q <= 1'b0;
      good_q   <= 4'd0;
      errc_q   <= 8'd0;
    end else begin
      sync1_q  <= mon.mon_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      high_q   <= high_d;
      low_q    <= low_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      duty_q   <= duty_d;
      perr_q   <= perr_d;
      stuck_q  <= stuck_d;
      locked_q <= locked_d;
      good_q   <= good_d;
      errc_q   <= errc_d;
    end
  end

  assign mon.high_cnt   = high_q;
  assign mon.low_cnt    = low_q;
  assign mon.period_cnt = period_q;
  assign mon.meas_valid = valid_q;
  assign mon.duty_err   = duty_q;
  assign mon.period_err = perr_q;
  assign mon.stuck_err  = stuck_q;
  assign mon.locked     = locked_q;
  assign mon.err_count  = errc_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: two instances (TOL=0 and TOL=1) see the
// same divided clock; expected measurements are queued and popped on meas_valid.
module tb_clk_div_monitor;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic enable = 1'b0;
  logic mon_in = 1'b0;

  clk_div_monitor_if #(.CNT_W(8)) if0 ();
  clk_div_monitor_if #(.CNT_W(8)) if1 ();

  assign if0.enable = enable;
  assign if0.mon_in = mon_in;
  assign if1.enable = enable;
  assign if1.mon_in = mon_in;

  clk_div_monitor #(.CNT_W(8), .EXP_HIGH(3), .EXP_LOW(3), .TOL(0), .LOCK_CNT(4))
    dut0 (.clk(clk), .reset_L(reset_L), .mon(if0));
  clk_div_monitor #(.CNT_W(8), .EXP_HIGH(3), .EXP_LOW(3), .TOL(1), .LOCK_CNT(4))
    dut1 (.clk(clk), .reset_L(reset_L), .mon(if1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] l;
    logic [8:0] p;
    logic       d;
    logic       pe;
    logic       lk;
    logic [7:0] ec;
  } meas_t;

  meas_t q0[$];
  meas_t q1[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    gr[2];
  int    ec[2];
  bit    lk[2];
  int    tol[2] = '{0, 1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic push_meas(input int h, input int l);
    for (int i = 0; i < 2; i++) begin
      meas_t m;
      bit    d;
      bit    pe;
      d  = (absd(h, 3) > tol[i]) || (absd(l, 3) > tol[i]);
      pe = absd(h + l, 6) > tol[i];
      if (d || pe) begin
        gr[i] = 0;
        lk[i] = 1'b0;
        if (ec[i] < 255) ec[i]++;
      end else begin
        if (gr[i] < 4) gr[i]++;
        lk[i] = (gr[i] == 4);
      end
      m.h  = 8'(h);
      m.l  = 8'(l);
      m.p  = 9'(h + l);
      m.d  = d;
      m.pe = pe;
      m.lk = lk[i];
      m.ec = 8'(ec[i]);
      if (i == 0) q0.push_back(m);
      else        q1.push_back(m);
    end
  endtask

  task automatic model_disable();
    for (int i = 0; i < 2; i++) begin
      gr[i] = 0;
      lk[i] = 1'b0;
    end
  endtask

  task automatic model_stuck();
    for (int i = 0; i < 2; i++) begin
      gr[i] = 0;
      lk[i] = 1'b0;
      if (ec[i] < 255) ec[i]++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      gr[i] = 0;
      lk[i] = 1'b0;
      ec[i] = 0;
    end
  endtask

  // Scoreboard side: compare every published measurement against the queue head.
  initial begin
    meas_t e;
    meas_t o;
    forever begin
      @(posedge clk);
      #1;
      if (if0.meas_valid === 1'b1) begin
        if (q0.size() == 0) check("dut0 spurious meas_valid", 64'(if0.meas_valid), 64'd0);
        else begin
          e = q0.pop_front();
          o = {if0.high_cnt, if0.low_cnt, if0.period_cnt, if0.duty_err,
               if0.period_err, if0.locked, if0.err_count};
          check("dut0 meas {h,l,p,duty,per,lock,errc}", 64'(o), 64'(e));
        end
      end
      if (if1.meas_valid === 1'b1) begin
        if (q1.size() == 0) check("dut1 spurious meas_valid", 64'(if1.meas_valid), 64'd0);
        else begin
          e = q1.pop_front();
          o = {if1.high_cnt, if1.low_cnt, if1.period_cnt, if1.duty_err,
               if1.period_err, if1.locked, if1.err_count};
          check("dut1 meas {h,l,p,duty,per,lock,errc}", 64'(o), 64'(e));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic period(input int h, input int l, input bit push);
    if (push) push_meas(h, l);
    mon_in = 1'b1;
    cyc(h);
    mon_in = 1'b0;
    cyc(l);
  endtask

  task automatic drain(input string tag);
    check({tag, " dut0 pending"}, 64'(q0.size()), 64'd0);
    check({tag, " dut1 pending"}, 64'(q1.size()), 64'd0);
  endtask

  // A trailing rise publishes the last queued period, then measurement stops.
  task automatic finish_seq(input string tag);
    mon_in = 1'b1;
    cyc(6);
    enable = 1'b0;
    model_disable();
    cyc(2);
    mon_in = 1'b0;
    cyc(4);
    drain(tag);
    check({tag, " dut0 locked after disable"}, 64'(if0.locked), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " dut0 outputs"}, 64'({if0.high_cnt, if0.low_cnt, if0.period_cnt,
          if0.meas_valid, if0.duty_err, if0.period_err, if0.stuck_err,
          if0.locked, if0.err_count}), 64'd0);
    check({tag, " dut1 outputs"}, 64'({if1.high_cnt, if1.low_cnt, if1.period_cnt,
          if1.meas_valid, if1.duty_err, if1.period_err, if1.stuck_err,
          if1.locked, if1.err_count}), 64'd0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    cyc(3);
    check_all_zero("reset");
    reset_L = 1'b1;
    cyc(2);

    // Nominal 3/3 lock, one 4/2 duty error, relock.
    enable = 1'b1;
    cyc(4);
    repeat (8) period(3, 3, 1'b1);
    period(4, 2, 1'b1);
    repeat (4) period(3, 3, 1'b1);
    finish_seq("lock");

    // 4/4: period error only under TOL=1, both errors under TOL=0.
    enable = 1'b1;
    cyc(4);
    period(4, 4, 1'b1);
    period(3, 3, 1'b1);
    finish_seq("tol");

    // Reset pulse while counting the low phase.
    enable = 1'b1;
    cyc(4);
    period(3, 3, 1'b1);
    period(3, 3, 1'b1);
    mon_in = 1'b1;
    cyc(3);
    mon_in = 1'b0;
    cyc(4);
    drain("pre-reset");
    reset_L = 1'b0;
    cyc(1);
    reset_L = 1'b1;
    model_reset();
    check_all_zero("mid-low reset");
    cyc(3);
    period(3, 3, 1'b1);
    period(3, 3, 1'b1);
    finish_seq("post-reset");

    // Stuck high, then recovery with the sticky flag retained.
    enable = 1'b1;
    cyc(4);
    mon_in = 1'b1;
    cyc(300);
    model_stuck();
    check("dut0 stuck_err", 64'(if0.stuck_err), 64'd1);
    check("dut1 stuck_err", 64'(if1.stuck_err), 64'd1);
    check("dut0 err_count after stuck", 64'(if0.err_count), 64'(ec[0]));
    check("dut0 locked after stuck", 64'(if0.locked), 64'd0);
    mon_in = 1'b0;
    cyc(3);
    repeat (5) period(3, 3, 1'b1);
    finish_seq("stuck recover");
    check("dut0 stuck_err sticky", 64'(if0.stuck_err), 64'd1);

    // Enable drop mid-measurement after lock.
    enable = 1'b1;
    cyc(4);
    repeat (5) period(3, 3, 1'b1);
    mon_in = 1'b1;
    cyc(3);
    mon_in = 1'b0;
    cyc(2);
    check("dut0 locked before drop", 64'(if0.locked), 64'(lk[0]));
    enable = 1'b0;
    model_disable();
    cyc(2);
    check("dut0 locked after drop", 64'(if0.locked), 64'd0);
    check("dut0 high_cnt held", 64'(if0.high_cnt), 64'd3);
    check("dut1 err_count held", 64'(if1.err_count), 64'(ec[1]));
    drain("drop");
    enable = 1'b1;
    cyc(3);
    period(4, 2, 1'b1);
    period(3, 3, 1'b1);
    finish_seq("re-enable");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Receive-side checker for divided clocks produced by the team's odd/even 50%-duty dividers (e.g. the divide-by-3 generator).
- Samples the divided clock with a faster system clock and measures high time, low time and period in sample cycles.
- Flags duty and period errors, and asserts lock after a run of good periods.
- Sits in the clocking test/debug subsystem next to the divider under observation.

Parameters:
- CNT_W, 8, width of high/low phase counters
- EXP_HIGH, 3, expected high phase length in sample cycles
- EXP_LOW, 3, expected low phase length in sample cycles
- TOL, 0, allowed absolute deviation per phase and for the period
- LOCK_CNT, 4, consecutive good periods required to assert locked (1..15)

Ports:
- clk, input, 1, sampling clock
- reset_L, input, 1, synchronous active-low reset; sampled on posedge clk
- enable, input, 1, measurement enable
- mon_in, input, 1, divided clock under test; asynchronous to clk
- high_cnt, output, CNT_W, last measured high phase length
- low_cnt, output, CNT_W, last measured low phase length
- period_cnt, output, CNT_W+1, high_cnt+low_cnt of the last measurement
- meas_valid, output, 1, one-cycle pulse when a new measurement is published
- duty_err, output, 1, last measurement phase out of tolerance
- period_err, output, 1, last measurement period out of tolerance
- stuck_err, output, 1, sticky; mon_in held one level for 2^CNT_W-1 cycles
- locked, output, 1, LOCK_CNT consecutive good measurements seen
- err_count, output, 8, saturating count of bad measurements

Behaviour:
- Reset: reset_L=0 at posedge clk clears every output, synchronizer, counter and state to 0; FSM goes to IDLE.
- Input capture: mon_in passes through a 2-flop synchronizer, then a third flop (prev) for edge detection.
  - rise = sync&~prev; fall = ~sync&prev.
  - mon_in transition to edge detect: 3 cycles.
- FSM states:
  - IDLE: stays while enable=0; enable=1 -> WAIT_RISE.
  - WAIT_RISE: discards the partial first period. rise -> MEAS_HIGH with hcnt<=1.
  - MEAS_HIGH: hcnt increments each cycle sync=1. fall -> MEAS_LOW with lcnt<=1.
  - MEAS_LOW: lcnt increments each cycle sync=0. On rise:
    - Publish high_cnt<=hcnt, low_cnt<=lcnt, period_cnt<=hcnt+lcnt (zero-extended, no overflow).
    - Pulse meas_valid for 1 cycle and update the error flags in the same cycle.
    - Restart MEAS_HIGH with hcnt<=1 (back-to-back periods, no gap).
- Error evaluation at publish:
  - duty_err = |hcnt-EXP_HIGH|>TOL or |lcnt-EXP_LOW|>TOL.
  - period_err = |(hcnt+lcnt)-(EXP_HIGH+EXP_LOW)|>TOL.
  - Both flags hold until the next publish.
- Lock: a good measurement (neither error) increments good_run, saturating at LOCK_CNT.
  - locked=1 in the same cycle good_run reaches LOCK_CNT.
  - Any bad measurement clears good_run and locked and increments err_count (saturates at 255).
- Stuck detection: hcnt or lcnt reaching 2^CNT_W-1 triggers all of the following:
  - stuck_err<=1 (sticky until reset), locked<=0, good_run<=0, err_count+1.
  - FSM -> WAIT_RISE; no meas_valid.
- enable deassert in any state: next cycle -> IDLE, locked<=0, good_run<=0. Measurement outputs and err_count hold.
- Simultaneous events:
  - reset_L=0 beats everything.
  - Stuck saturation and an edge in the same cycle: the edge wins; counters hold at max, no stuck flag, and the measurement publishes with saturated value.
- Glitch shorter than 1 sample cycle may be missed; pulses of 1 sample cycle are measured as length 1.

Test Plan:
- Drive mon_in high 3/low 3 for 8 periods, default params -> first meas_valid after the first full period; high_cnt=3, low_cnt=3, period_cnt=6, no errors; locked=1 on the 4th meas_valid; err_count=0.
- After lock, one period high 4/low 2 -> duty_err=1, period_err=0, locked=0, err_count=1; relock after 4 more good periods.
- High 4/low 4 with TOL=1 -> no duty_err, period_err=1 (8 vs 6 > 1).
- Hold mon_in=1 for 300 cycles, CNT_W=8 -> stuck_err=1 at hcnt=255, no meas_valid, err_count=1; resumed 3/3 toggling -> relock while stuck_err stays 1.
- reset_L=0 for 1 cycle mid MEAS_LOW -> all outputs 0 on the next cycle; first meas_valid only after a full rise-to-rise period.
- enable=0 mid-measurement, then 1 -> locked=0, old high_cnt held; no meas_valid until a full period after re-enable.
